// File: rtl/alu_pkg.sv
// alu_pkg: opcodes, FSM state type and op classification shared by the multicycle ALU.
package alu_pkg;
    localparam logic [3:0] ALU_AND   = 4'b0000;
    localparam logic [3:0] ALU_OR    = 4'b0001;
    localparam logic [3:0] ALU_ADD   = 4'b0010;
    localparam logic [3:0] ALU_ANDN  = 4'b0100;
    localparam logic [3:0] ALU_ORN   = 4'b0101;
    localparam logic [3:0] ALU_SUB   = 4'b0110;
    localparam logic [3:0] ALU_SLT   = 4'b0111;
    localparam logic [3:0] ALU_SLTU  = 4'b1000;
    localparam logic [3:0] ALU_SLL   = 4'b1001;
    localparam logic [3:0] ALU_SRL   = 4'b1010;
    localparam logic [3:0] ALU_SRA   = 4'b1011;
    localparam logic [3:0] ALU_MULTU = 4'b1100;
    localparam logic [3:0] ALU_DIVU  = 4'b1101;

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_e;

    function automatic logic is_multicycle(input logic [3:0] op);
        return op == ALU_MULTU || op == ALU_DIVU;
    endfunction
endpackage

// File: rtl/alu_muldiv_iter.sv
// alu_muldiv_iter: one-bit-per-cycle unsigned shift-add multiply / restoring divide.
// lo/hi present the post-iteration values so the caller can capture them on the done cycle.
module alu_muldiv_iter
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             done,
    output logic [WIDTH-1:0] lo,
    output logic [WIDTH-1:0] hi,
    output logic             dbz
);
    localparam int CW = $clog2(WIDTH);

    logic             busy_q, div_q;
    logic [CW-1:0]    count_q;
    logic [WIDTH-1:0] b_q, hi_q, lo_q, hi_d, lo_d;
    logic [WIDTH:0]   add_sum, rem_shift;
    logic [WIDTH-1:0] rem_diff;
    logic             rem_lt;

    // hi/lo double as {product high, multiplier} or {remainder, dividend/quotient}
    always_comb begin
        add_sum   = {1'b0, hi_q} + {1'b0, lo_q[0] ? b_q : '0};
        rem_shift = {hi_q, lo_q[WIDTH-1]};
        rem_lt    = rem_shift < {1'b0, b_q};
        rem_diff  = rem_shift[WIDTH-1:0] - b_q;
        hi_d      = div_q ? (rem_lt ? rem_shift[WIDTH-1:0] : rem_diff) : add_sum[WIDTH:1];
        lo_d      = div_q ? {lo_q[WIDTH-2:0], ~rem_lt} : {add_sum[0], lo_q[WIDTH-1:1]};
    end

    assign done = busy_q && count_q == CW'(WIDTH - 1);
    assign lo   = lo_d;
    assign hi   = hi_d;
    assign dbz  = div_q && b_q == '0;

    always_ff @(posedge clk) begin
        if (reset) begin
            busy_q  <= 1'b0;
            div_q   <= 1'b0;
            count_q <= '0;
            b_q     <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
        end else if (start) begin
            busy_q  <= 1'b1;
            div_q   <= op == ALU_DIVU;
            count_q <= '0;
            b_q     <= b;
            hi_q    <= '0;
            lo_q    <= a;
        end else if (busy_q) begin
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            count_q <= count_q + 1'b1;
            if (done) busy_q <= 1'b0;
        end
    end
endmodule

// File: rtl/alu_multicycle.sv
// alu_multicycle: registered ALU with valid/ready handshake and iterative MULTU/DIVU.
// Define ALU_OVF_EN to add the registered signed-overflow output for ADD/SUB.
module alu_multicycle
    import alu_pkg::*;
#(
    parameter  int WIDTH = 32,
    localparam int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       alu_ctl,
    input  logic [WIDTH-1:0] src_a,
    input  logic [WIDTH-1:0] src_b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic [WIDTH-1:0] result_hi,
    output logic             zero,
    output logic             div_by_zero
`ifdef ALU_OVF_EN
    ,
    output logic             overflow
`endif
);
    state_e           state_q, state_d;
    logic             accept, load_fast, load_iter, load;
    logic [WIDTH-1:0] sum, diff, fast_res;
    logic [SHW-1:0]   shamt;
    logic [WIDTH-1:0] result_q, result_d, result_hi_q, result_hi_d;
    logic             zero_q, zero_d, dbz_q, dbz_d;
    logic             it_done, it_dbz;
    logic [WIDTH-1:0] it_lo, it_hi;

    assign in_ready  = state_q == IDLE || (state_q == DONE && out_ready);
    assign out_valid = state_q == DONE;
    assign accept    = in_valid && in_ready;
    assign load_fast = accept && !is_multicycle(alu_ctl);
    assign load_iter = state_q == BUSY && it_done;
    assign load      = load_fast || load_iter;
    assign sum       = src_a + src_b;
    assign diff      = src_a - src_b;
    assign shamt     = src_b[SHW-1:0];

    alu_muldiv_iter #(.WIDTH(WIDTH)) u_iter (
        .clk   (clk),
        .reset (reset),
        .start (accept && is_multicycle(alu_ctl)),
        .op    (alu_ctl),
        .a     (src_a),
        .b     (src_b),
        .done  (it_done),
        .lo    (it_lo),
        .hi    (it_hi),
        .dbz   (it_dbz)
    );

    always_comb begin
        fast_res = '0;
        case (alu_ctl)
            ALU_AND:  fast_res = src_a & src_b;
            ALU_OR:   fast_res = src_a | src_b;
            ALU_ADD:  fast_res = sum;
            ALU_ANDN: fast_res = src_a & ~src_b;
            ALU_ORN:  fast_res = src_a | ~src_b;
            ALU_SUB:  fast_res = diff;
            ALU_SLT:  fast_res = {{(WIDTH-1){1'b0}}, $signed(src_a) < $signed(src_b)};
            ALU_SLTU: fast_res = {{(WIDTH-1){1'b0}}, src_a < src_b};
            ALU_SLL:  fast_res = src_a << shamt;
            ALU_SRL:  fast_res = src_a >> shamt;
            ALU_SRA:  fast_res = $signed(src_a) >>> shamt;
            default:  fast_res = '0;
        endcase
    end

    // DONE with out_ready behaves like IDLE so back-to-back requests stream at 1/cycle
    always_comb begin
        state_d     = state_q == BUSY ? (it_done ? DONE : BUSY)
                    : accept ? (is_multicycle(alu_ctl) ? BUSY : DONE)
                    : (state_q == DONE && out_ready) ? IDLE : state_q;
        result_d    = load_iter ? it_lo : load_fast ? fast_res : result_q;
        result_hi_d = load_iter ? it_hi : load_fast ? '0 : result_hi_q;
        dbz_d       = load_iter ? it_dbz : load_fast ? 1'b0 : dbz_q;
        zero_d      = load ? result_d == '0 : zero_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            result_q    <= '0;
            result_hi_q <= '0;
            zero_q      <= 1'b0;
            dbz_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            result_q    <= result_d;
            result_hi_q <= result_hi_d;
            zero_q      <= zero_d;
            dbz_q       <= dbz_d;
        end
    end

    assign result      = result_q;
    assign result_hi   = result_hi_q;
    assign zero        = zero_q;
    assign div_by_zero = dbz_q;

`ifdef ALU_OVF_EN
    logic ovf_q, ovf_d, fast_ovf;

    always_comb begin
        fast_ovf = (alu_ctl == ALU_ADD && src_a[WIDTH-1] == src_b[WIDTH-1] && sum[WIDTH-1] != src_a[WIDTH-1])
                || (alu_ctl == ALU_SUB && src_a[WIDTH-1] != src_b[WIDTH-1] && diff[WIDTH-1] != src_a[WIDTH-1]);
        ovf_d    = load_iter ? 1'b0 : load_fast ? fast_ovf : ovf_q;
    end

    always_ff @(posedge clk) begin
        if (reset) ovf_q <= 1'b0;
        else       ovf_q <= ovf_d;
    end

    assign overflow = ovf_q;
`endif
endmodule
